// File: rtl/blankport_slice_sched.sv
// Round-robin scheduler that time-shares one SLICE-wide blankport cell among NREQ requesters.
// Optional parity output/checker enabled by defining BLANKPORT_SCHED_PARITY_EN.
module blankport_slice_sched #(
    parameter int unsigned NREQ  = 2,
    parameter int unsigned W     = 4,
    parameter int unsigned SLICE = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [NREQ*W-1:0]       req_a,
    input  logic [NREQ*W-1:0]       req_b,
    output logic [NREQ-1:0]         req_ready,
    output logic [SLICE-1:0]        cell_a,
    output logic [SLICE-1:0]        cell_b,
    input  logic [SLICE-1:0]        cell_o,
    output logic                    rsp_valid,
    output logic [$clog2(NREQ)-1:0] rsp_id,
    output logic [W-1:0]            rsp_data,
`ifdef BLANKPORT_SCHED_PARITY_EN
    output logic                    rsp_par,
    output logic                    par_err,
`endif
    input  logic                    rsp_ready
);

    localparam int unsigned IDW    = $clog2(NREQ);
    localparam int unsigned NSLICE = W / SLICE;
    localparam int unsigned CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_RESP} state_e;

    state_e            state_q, state_d;
    logic [IDW-1:0]    rr_ptr_q, rr_ptr_d;
    logic [CW-1:0]     slice_cnt_q, slice_cnt_d;
    logic [IDW-1:0]    own_q, own_d;
    logic [W-1:0]      op_a_q, op_a_d;
    logic [W-1:0]      op_b_q, op_b_d;
    logic [W-1:0]      res_q, res_d;
    logic [SLICE-1:0]  cell_a_q, cell_a_d;
    logic [SLICE-1:0]  cell_b_q, cell_b_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [IDW-1:0]    rsp_id_q, rsp_id_d;
    logic [W-1:0]      rsp_data_q, rsp_data_d;
`ifdef BLANKPORT_SCHED_PARITY_EN
    logic              rsp_par_q, rsp_par_d;
    logic              par_err_q, par_err_d;
`endif

    logic              grant_hit;
    logic [IDW-1:0]    grant_id;
    int unsigned       arb_idx;
    int unsigned       gbase;
    int unsigned       sbase;
    logic              last_slice;

    assign last_slice = (slice_cnt_q == CW'(NSLICE - 1));

    // First valid requester at or after rr_ptr, searching upward with wrap
    always_comb begin
        grant_hit = 1'b0;
        grant_id  = '0;
        arb_idx   = 0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            arb_idx = (32'(rr_ptr_q) + k) % NREQ;
            if (!grant_hit && req_valid[IDW'(arb_idx)]) begin
                grant_hit = 1'b1;
                grant_id  = IDW'(arb_idx);
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (state_q == S_IDLE && !reset && grant_hit) begin
            req_ready = NREQ'(1) << grant_id;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (grant_hit)  state_d = S_ISSUE;
            S_ISSUE: if (last_slice) state_d = S_RESP;
            S_RESP:  if (rsp_ready)  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath: latch operands on grant, walk slices LSB first, present result
    always_comb begin
        rr_ptr_d    = rr_ptr_q;
        slice_cnt_d = slice_cnt_q;
        own_d       = own_q;
        op_a_d      = op_a_q;
        op_b_d      = op_b_q;
        res_d       = res_q;
        cell_a_d    = cell_a_q;
        cell_b_d    = cell_b_q;
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_data_d  = rsp_data_q;
`ifdef BLANKPORT_SCHED_PARITY_EN
        rsp_par_d   = rsp_par_q;
        par_err_d   = par_err_q;
`endif
        gbase       = 32'(grant_id) * W;
        sbase       = 32'(slice_cnt_q) * SLICE;
        case (state_q)
            S_IDLE: begin
                if (grant_hit) begin
                    op_a_d      = req_a[gbase +: W];
                    op_b_d      = req_b[gbase +: W];
                    cell_a_d    = req_a[gbase +: SLICE];
                    cell_b_d    = req_b[gbase +: SLICE];
                    own_d       = grant_id;
                    slice_cnt_d = '0;
                    rr_ptr_d    = (grant_id == IDW'(NREQ - 1)) ? '0 : IDW'(grant_id + 1'b1);
                end
            end
            S_ISSUE: begin
                res_d[sbase +: SLICE] = cell_o;
`ifdef BLANKPORT_SCHED_PARITY_EN
                // X/Z on cell_o or a parity disagreement both make this non-zero
                if (((^cell_o) ^ (^cell_a_q) ^ (^cell_b_q)) !== 1'b0) begin
                    par_err_d = 1'b1;
                end
`endif
                if (last_slice) begin
                    slice_cnt_d = '0;
                    rsp_valid_d = 1'b1;
                    rsp_id_d    = own_q;
                    rsp_data_d  = res_d;
`ifdef BLANKPORT_SCHED_PARITY_EN
                    rsp_par_d   = ^res_d;
`endif
                end else begin
                    slice_cnt_d = CW'(slice_cnt_q + 1'b1);
                    cell_a_d    = op_a_q[sbase + SLICE +: SLICE];
                    cell_b_d    = op_b_q[sbase + SLICE +: SLICE];
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr_q    <= '0;
            slice_cnt_q <= '0;
            own_q       <= '0;
            op_a_q      <= '0;
            op_b_q      <= '0;
            res_q       <= '0;
            cell_a_q    <= '0;
            cell_b_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_data_q  <= '0;
`ifdef BLANKPORT_SCHED_PARITY_EN
            rsp_par_q   <= 1'b0;
            par_err_q   <= 1'b0;
`endif
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            slice_cnt_q <= slice_cnt_d;
            own_q       <= own_d;
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
            res_q       <= res_d;
            cell_a_q    <= cell_a_d;
            cell_b_q    <= cell_b_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_data_q  <= rsp_data_d;
`ifdef BLANKPORT_SCHED_PARITY_EN
            rsp_par_q   <= rsp_par_d;
            par_err_q   <= par_err_d;
`endif
        end
    end

    assign cell_a    = cell_a_q;
    assign cell_b    = cell_b_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_data  = rsp_data_q;
`ifdef BLANKPORT_SCHED_PARITY_EN
    assign rsp_par   = rsp_par_q;
    assign par_err   = par_err_q;
`endif

endmodule

// File: tb/tb_blankport_slice_sched.sv
// Directed bench for blankport_slice_sched: default 2-requester instance plus a 3-requester instance.
module tb_blankport_slice_sched;

    logic        clk;
    logic        reset;

    logic [1:0]  rv2, rr2;
    logic [7:0]  ra2, rb2;
    logic [1:0]  ca2, cb2, co2;
    logic        rsv2, rrdy2, flip2;
    logic [0:0]  rid2;
    logic [3:0]  rd2;

    logic [2:0]  rv3, rr3;
    logic [11:0] ra3, rb3;
    logic [1:0]  ca3, cb3, co3;
    logic        rsv3, rrdy3;
    logic [1:0]  rid3;
    logic [3:0]  rd3;

`ifdef BLANKPORT_SCHED_PARITY_EN
    logic        rsp_par2, par_err2, rsp_par3, par_err3;
`endif

    int total;
    int bad;

    // Shared-cell model: XOR, with an injectable bit flip on the 2-requester instance
    assign co2 = (ca2 ^ cb2) ^ {1'b0, flip2};
    assign co3 = ca3 ^ cb3;

    blankport_slice_sched #(.NREQ(2), .W(4), .SLICE(2)) dut2 (
        .clk(clk), .reset(reset),
        .req_valid(rv2), .req_a(ra2), .req_b(rb2), .req_ready(rr2),
        .cell_a(ca2), .cell_b(cb2), .cell_o(co2),
        .rsp_valid(rsv2), .rsp_id(rid2), .rsp_data(rd2),
`ifdef BLANKPORT_SCHED_PARITY_EN
        .rsp_par(rsp_par2), .par_err(par_err2),
`endif
        .rsp_ready(rrdy2)
    );

    blankport_slice_sched #(.NREQ(3), .W(4), .SLICE(2)) dut3 (
        .clk(clk), .reset(reset),
        .req_valid(rv3), .req_a(ra3), .req_b(rb3), .req_ready(rr3),
        .cell_a(ca3), .cell_b(cb3), .cell_o(co3),
        .rsp_valid(rsv3), .rsp_id(rid3), .rsp_data(rd3),
`ifdef BLANKPORT_SCHED_PARITY_EN
        .rsp_par(rsp_par3), .par_err(par_err3),
`endif
        .rsp_ready(rrdy3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [1:0] exp_g  [3];
        logic [3:0] exp_d  [3];
        logic       exp_id [3];
        total = 0;
        bad   = 0;
        exp_g  = '{2'b01, 2'b10, 2'b01};
        exp_d  = '{4'hD, 4'h5, 4'hD};
        exp_id = '{1'b0, 1'b1, 1'b0};

        reset = 1'b1; flip2 = 1'b0;
        rv2 = '0; ra2 = '0; rb2 = '0; rrdy2 = 1'b1;
        rv3 = '0; ra3 = '0; rb3 = '0; rrdy3 = 1'b1;
        step(); step();

        // Reset state: no grant even with a request pending
        rv2 = 2'b01; #1;
        chk("rst_ready", 32'(rr2), 32'd0);
        chk("rst_valid", 32'(rsv2), 32'd0);
        chk("rst_data", 32'(rd2), 32'd0);
        chk("rst_cell_a", 32'(ca2), 32'd0);
        chk("rst_id", 32'(rid2), 32'd0);
        rv2 = '0; reset = 1'b0;
        step();

        // Single request A/5 on id0
        ra2 = 8'h0A; rb2 = 8'h05; rv2 = 2'b01; #1;
        chk("single_ready", 32'(rr2), 32'd1);
        step(); rv2 = '0; #1;
        chk("single_ca_s0", 32'(ca2), 32'd2);
        chk("single_cb_s0", 32'(cb2), 32'd1);
        chk("single_ready_issue", 32'(rr2), 32'd0);
        chk("single_nvalid_t1", 32'(rsv2), 32'd0);
        step();
        chk("single_ca_s1", 32'(ca2), 32'd2);
        chk("single_cb_s1", 32'(cb2), 32'd1);
        chk("single_nvalid_t2", 32'(rsv2), 32'd0);
        step();
        chk("single_valid", 32'(rsv2), 32'd1);
        chk("single_data", 32'(rd2), 32'hF);
        chk("single_id", 32'(rid2), 32'd0);
        step();
        chk("single_drop", 32'(rsv2), 32'd0);

        // Reset while issuing slice 0 aborts the transaction
        ra2 = 8'h03; rb2 = 8'h01; rv2 = 2'b01; #1;
        chk("abort_grant", 32'(rr2), 32'd1);
        step(); rv2 = '0;
        reset = 1'b1;
        step(); reset = 1'b0; #1;
        chk("abort_valid", 32'(rsv2), 32'd0);
        chk("abort_data", 32'(rd2), 32'd0);
        chk("abort_cell_a", 32'(ca2), 32'd0);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("abort_no_rsp", 32'(rsv2), 32'd0);
        end

        // Contention: both held, grants alternate from rr_ptr=0
        ra2 = 8'h3C; rb2 = 8'h61; rv2 = 2'b11; rrdy2 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("cont_grant", 32'(rr2), 32'(exp_g[i]));
            step(); step(); step();
            chk("cont_valid", 32'(rsv2), 32'd1);
            chk("cont_id", 32'(rid2), 32'(exp_id[i]));
            chk("cont_data", 32'(rd2), 32'(exp_d[i]));
            step();
        end

        // Backpressure: response held for 6 cycles, no grant meanwhile
        rv2 = 2'b10; rrdy2 = 1'b0; #1;
        chk("bp_grant", 32'(rr2), 32'd2);
        step(); step(); step();
        chk("bp_valid", 32'(rsv2), 32'd1);
        chk("bp_id", 32'(rid2), 32'd1);
        chk("bp_data", 32'(rd2), 32'h5);
        rv2 = 2'b11;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("bp_hold_data", 32'(rd2), 32'h5);
            chk("bp_hold_valid", 32'(rsv2), 32'd1);
            chk("bp_hold_ready", 32'(rr2), 32'd0);
        end
        rrdy2 = 1'b1;
        step();
        rv2 = 2'b01; #1;
        chk("bp_release_valid", 32'(rsv2), 32'd0);
        chk("bp_release_grant", 32'(rr2), 32'd1);
        step(); rv2 = '0;
        step(); step();
        chk("bp_next_id", 32'(rid2), 32'd0);
        chk("bp_next_data", 32'(rd2), 32'hD);
        step();

        // NREQ=3: grant id2 wraps rr_ptr to 0
        ra3 = 12'h900; rb3 = 12'h400; rv3 = 3'b100; #1;
        chk("wrap_grant2", 32'(rr3), 32'd4);
        step(); rv3 = '0;
        step(); step();
        chk("wrap_valid", 32'(rsv3), 32'd1);
        chk("wrap_id2", 32'(rid3), 32'd2);
        chk("wrap_data2", 32'(rd3), 32'hD);
        step();
        ra3 = 12'h00A; rb3 = 12'h005; rv3 = 3'b011; #1;
        chk("wrap_grant0", 32'(rr3), 32'd1);
        step(); rv3 = '0;
        step(); step();
        chk("wrap_id0", 32'(rid3), 32'd0);
        chk("wrap_data0", 32'(rd3), 32'hF);
        step();
        step();
        chk("idle_no_grant", 32'(rr3), 32'd0);
        ra3 = 12'h070; rb3 = 12'h010; rv3 = 3'b111; #1;
        chk("idle_keeps_ptr", 32'(rr3), 32'd2);
        step(); rv3 = '0;
        step(); step();
        chk("idle_id1", 32'(rid3), 32'd1);
        chk("idle_data1", 32'(rd3), 32'h6);
        step();

`ifdef BLANKPORT_SCHED_PARITY_EN
        chk("par_clean", 32'(par_err2), 32'd0);
        chk("par_rsp_par", 32'(rsp_par2), 32'd1);
        chk("par_clean3", 32'(par_err3), 32'd0);
        flip2 = 1'b1;
        ra2 = 8'h0A; rb2 = 8'h05; rv2 = 2'b01;
        step(); rv2 = '0;
        step(); #1;
        chk("par_set", 32'(par_err2), 32'd1);
        flip2 = 1'b0;
        step(); step(); step();
        chk("par_sticky", 32'(par_err2), 32'd1);
        reset = 1'b1;
        step(); reset = 1'b0; #1;
        chk("par_reset", 32'(par_err2), 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
